// File: rtl/knn_pkg.sv
// Shared types, widths and helper functions for the KNN stream controller.
package knn_pkg;

    localparam int DIST_W = 32;
    localparam int IDX_W  = 16;
    localparam logic [DIST_W-1:0] DIST_MAX = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((64'(1) << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

    // Address width that never collapses to zero bits.
    function automatic int addr_w(input int depth);
        return (clog2(depth) > 0) ? clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/knn_topk_insert.sv
// Sorted K-entry table of the smallest distances seen; one parallel
// compare-and-shift insert per cycle, entry 0 nearest, ties keep arrival order.
module knn_topk_insert
    import knn_pkg::*;
#(
    parameter int K      = 4,
    parameter int DIST_W = 32,
    parameter int IDX_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [DIST_W-1:0]     in_dist,
    input  logic [IDX_W-1:0]      in_idx,
    output logic [DIST_W*K-1:0]   tbl_dist,
    output logic [IDX_W*K-1:0]    tbl_idx
);

    logic [DIST_W*K-1:0] dist_q;
    logic [DIST_W*K-1:0] dist_nxt;
    logic [DIST_W*K-1:0] dist_above;
    logic [IDX_W*K-1:0]  idx_q;
    logic [IDX_W*K-1:0]  idx_nxt;
    logic [IDX_W*K-1:0]  idx_above;
    logic [K-1:0]        lt_vec;
    logic [K-1:0]        lt_prev;

    // Compute the post-insert table: slot p takes the new entry if it is the
    // first slot the new distance beats, the entry above it if a slot above was
    // already beaten, otherwise it keeps its own entry.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        dist_nxt = dist_q;
        idx_nxt  = idx_q;
        lt_vec   = '0;
        for (int p = 0; p < K; p++) begin
            lt_vec[p] = in_dist < dist_q[p*DIST_W +: DIST_W];
        end
        lt_prev    = lt_vec << 1;
        dist_above = dist_q << DIST_W;
        idx_above  = idx_q << IDX_W;
        if (in_valid) begin
            for (int p = 0; p < K; p++) begin
                if (lt_vec[p]) begin
                    if (lt_prev[p]) begin
                        dist_nxt[p*DIST_W +: DIST_W] = dist_above[p*DIST_W +: DIST_W];
                        idx_nxt[p*IDX_W +: IDX_W]    = idx_above[p*IDX_W +: IDX_W];
                    end else begin
                        dist_nxt[p*DIST_W +: DIST_W] = in_dist;
                        idx_nxt[p*IDX_W +: IDX_W]    = in_idx;
                    end
                end
            end
        end
    end

    // Table register: cleared to "empty" (all-ones distance) on reset or run start.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the table is a small register array, not a RAM, so it is reset
        // directly; an empty slot must read as the largest distance.
        if (rst) begin
            dist_q <= {K{DIST_MAX[DIST_W-1:0]}};
            idx_q  <= '0;
        end else if (clr) begin
            dist_q <= {K{DIST_MAX[DIST_W-1:0]}};
            idx_q  <= '0;
        end else begin
            // NOTE: non-blocking assignment for state so every register samples
            // pre-edge values regardless of statement order.
            dist_q <= dist_nxt;
            idx_q  <= idx_nxt;
        end
    end

    assign tbl_dist = dist_q;
    assign tbl_idx  = idx_q;

endmodule

// File: rtl/knn_stream_ctrl.sv
// Sequencer for one KNN distance PE: aligns to the PE frame, streams the test
// vector against every training vector with no gaps, and keeps the K nearest.
module knn_stream_ctrl
    import knn_pkg::*;
#(
    parameter  int SIZE      = 1,
    parameter  int BEATS     = 10000,
    parameter  int NUM_TRAIN = 1024,
    parameter  int K         = 4,
    localparam int TA_W      = addr_w(BEATS),
    localparam int TR_W      = addr_w(NUM_TRAIN * BEATS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [TA_W-1:0]       test_addr,
    output logic [TR_W-1:0]       train_addr,
    output logic                  mem_en,
    input  logic                  pe_done,
    input  logic [DIST_W-1:0]     pe_dist,
    output logic [DIST_W*K-1:0]   knn_dist,
    output logic [IDX_W*K-1:0]    knn_idx
);

    // Out-of-range configurations stop elaboration rather than misbehave.
    if (SIZE < 1 || K < 1 || K > 16 || NUM_TRAIN < 1 || NUM_TRAIN > 65536 || BEATS < 1) begin : g_param_check
        $fatal(1, "knn_stream_ctrl: unsupported parameter set");
    end

    localparam logic [TA_W-1:0]  TEST_LAST  = TA_W'(BEATS - 1);
    localparam logic [TR_W-1:0]  TRAIN_LAST = TR_W'(NUM_TRAIN * BEATS - 1);
    localparam logic [IDX_W-1:0] CAP_LAST   = IDX_W'(NUM_TRAIN - 1);

    state_t           state_q;
    state_t           state_d;
    logic             clr;
    logic             armed_q;
    logic [IDX_W-1:0] cap_cnt_q;
    logic             capture;
    logic             last_cap;

    // A PE frame end counts as a result only once the first aligned beat is out.
    assign capture  = armed_q & pe_done;
    assign last_cap = capture && (cap_cnt_q == CAP_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; memory reads are issued straight from here.
    always_comb begin
        state_d = state_q;
        mem_en  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                busy = 1'b1;
                // Issuing beat 0 alongside pe_done lands its data on the first
                // cycle of the PE's next frame.
                if (pe_done) begin
                    mem_en  = 1'b1;
                    state_d = (TRAIN_LAST == '0) ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                busy   = 1'b1;
                mem_en = 1'b1;
                if (train_addr == TRAIN_LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (last_cap) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read addresses: test wraps every vector, train runs linearly and holds at the end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            test_addr  <= '0;
            train_addr <= '0;
        end else if (clr) begin
            test_addr  <= '0;
            train_addr <= '0;
        end else if (mem_en) begin
            test_addr <= (test_addr == TEST_LAST) ? '0 : test_addr + 1'b1;
            if (train_addr != TRAIN_LAST) begin
                train_addr <= train_addr + 1'b1;
            end
        end
    end

    // Capture tracking: arm after the aligned beat 0, count one result per frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_q   <= 1'b0;
            cap_cnt_q <= '0;
        end else if (clr) begin
            armed_q   <= 1'b0;
            cap_cnt_q <= '0;
        end else begin
            if (state_q == ALIGN && pe_done) begin
                armed_q <= 1'b1;
            end
            if (capture) begin
                cap_cnt_q <= cap_cnt_q + 1'b1;
                if (cap_cnt_q == CAP_LAST) begin
                    armed_q <= 1'b0;
                end
            end
        end
    end

    knn_topk_insert #(
        .K      (K),
        .DIST_W (DIST_W),
        .IDX_W  (IDX_W)
    ) u_topk (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (capture),
        .in_dist  (pe_dist),
        .in_idx   (cap_cnt_q),
        .tbl_dist (knn_dist),
        .tbl_idx  (knn_idx)
    );

endmodule
